array_bubble_sort: RTL

In-place ascending (signed) sorter for a word array in data memory. It is the writer counterpart to the array sort checker: it reads adjacent pairs, swaps inversions through a single write port, and repeats passes until a pass makes no swap. It sits beside the checker on the same lab memory, which has two combinational read ports and one synchronous write port, and uses the same level-sensitive `go`/`done` handshake.

---
 rtl/array_sort_pkg.sv | 35 +++
 rtl/array_bubble_sort_control.sv | 118 +++++++++++
 rtl/array_bubble_sort.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/array_sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_sort_pkg
//  Description : Shared definitions for the array sort checker and the
//                in-place bubble sorter: element byte stride, one-hot state
//                encoding and the bit index of each state in that encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package array_sort_pkg;

    // Byte distance between consecutive array elements.
    localparam int ELEM_BYTES = 4;

    // One-hot state register width and the bit owned by each state.
    localparam int ST_W         = 7;
    localparam int IDLE_IDX     = 0;
    localparam int PREP_IDX     = 1;
    localparam int COMPARE_IDX  = 2;
    localparam int SWAP_LO_IDX  = 3;
    localparam int SWAP_HI_IDX  = 4;
    localparam int PASS_END_IDX = 5;
    localparam int DONE_IDX     = 6;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = 7'b000_0001,
        ST_PREP     = 7'b000_0010,
        ST_COMPARE  = 7'b000_0100,
        ST_SWAP_LO  = 7'b000_1000,
        ST_SWAP_HI  = 7'b001_0000,
        ST_PASS_END = 7'b010_0000,
        ST_DONE     = 7'b100_0000
    } state_t;

endpackage : array_sort_pkg
`default_nettype wire

// File: rtl/array_bubble_sort_control.sv
`default_nettype none
// ============================================================================
//  Module      : array_bubble_sort_control
//  Description : Sequencer for the bubble sorter. Holds the one-hot state
//                register, the next-state equations and the decode of the
//                datapath strobes.
//  Ports       : clock, reset        - clock, synchronous active-high reset
//                go                  - level-sensitive start request
//                inversion           - current pair is out of order (signed)
//                last_pair           - current pair is the last one of the pass
//                short_array         - requested length is below two
//                swapped             - a swap occurred in the current pass
//                last_pass           - shrinking the bound would leave < 2
//                busy, done          - handshake status
//                wr_en, wr_hi        - write strobe, select upper-element write
//                load                - (re)initialise datapath from the inputs
//                compare             - drive addresses, capture the pair
//                set_swap            - mark swap, bump swap counter
//                advance_i           - step to the next pair
//                restart_pass        - shrink bound, rewind to the first pair
//  Revision    : 1.0  initial release
// ============================================================================
module array_bubble_sort_control
    import array_sort_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic go,
    input  logic inversion,
    input  logic last_pair,
    input  logic short_array,
    input  logic swapped,
    input  logic last_pass,
    output logic busy,
    output logic done,
    output logic wr_en,
    output logic wr_hi,
    output logic load,
    output logic compare,
    output logic set_swap,
    output logic advance_i,
    output logic restart_pass
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        advance_i    = 1'b0;
        restart_pass = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (go) w_next = ST_PREP;
            end
            ST_PREP: begin
                if (!go) w_next = short_array ? ST_DONE : ST_COMPARE;
            end
            ST_COMPARE: begin
                if (inversion) begin
                    w_next = ST_SWAP_LO;
                end else if (last_pair) begin
                    w_next = ST_PASS_END;
                end else begin
                    advance_i = 1'b1;
                end
            end
            ST_SWAP_LO: begin
                w_next = ST_SWAP_HI;
            end
            ST_SWAP_HI: begin
                if (last_pair) begin
                    w_next = ST_PASS_END;
                end else begin
                    w_next    = ST_COMPARE;
                    advance_i = 1'b1;
                end
            end
            ST_PASS_END: begin
                if (!swapped || last_pass) begin
                    w_next = ST_DONE;
                end else begin
                    w_next       = ST_COMPARE;
                    restart_pass = 1'b1;
                end
            end
            ST_DONE: begin
                if (go) w_next = ST_PREP;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Initialising on PREP entry as well clears swap_count in the first
        // PREP cycle after a restart, not one cycle later.
        load     = r_state[PREP_IDX] || (w_next == ST_PREP);
        compare  = r_state[COMPARE_IDX];
        set_swap = r_state[SWAP_LO_IDX];
        wr_hi    = r_state[SWAP_HI_IDX];
        wr_en    = r_state[SWAP_LO_IDX] | r_state[SWAP_HI_IDX];
        busy     = r_state[PREP_IDX]    | r_state[COMPARE_IDX] |
                   r_state[SWAP_LO_IDX] | r_state[SWAP_HI_IDX] |
                   r_state[PASS_END_IDX];
        done     = r_state[DONE_IDX];
    end

endmodule : array_bubble_sort_control
`default_nettype wire

// File: rtl/array_bubble_sort.sv
`default_nettype none
// ============================================================================
//  Module      : array_bubble_sort
//  Description : In-place ascending signed bubble sort of a word array in a
//                memory with two combinational read ports and one synchronous
//                write port. Swaps take two write cycles (lower then upper).
//  Ports       : clock, reset              - clock, sync active-high reset
//                go                        - level-sensitive start request
//                array_base, array_length  - array location / element count
//                mem_addr_a, mem_addr_b    - read addresses of pair (i, i+1)
//                mem_data_a, mem_data_b    - combinational read data
//                mem_wr_en/addr/data       - write port
//                busy, done                - handshake status
//                swap_count                - swaps in current or last sort
//  Revision    : 1.0  initial release
// ============================================================================
module array_bubble_sort
    import array_sort_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] array_base,
    input  logic [31:0]       array_length,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    input  logic [DATA_W-1:0] mem_data_a,
    input  logic [DATA_W-1:0] mem_data_b,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       swap_count
);

    localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(ELEM_BYTES);

    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_i;
    logic [31:0]       r_bound;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_swapped;
    logic [31:0]       r_swap_count;
    logic [ADDR_W-1:0] r_hold_a;
    logic [ADDR_W-1:0] r_hold_b;

    logic [ADDR_W-1:0] w_addr_a;
    logic [ADDR_W-1:0] w_addr_b;
    logic              w_inversion;
    logic              w_last_pair;
    logic              w_short_array;
    logic              w_last_pass;
    logic              w_wr_hi;
    logic              w_load;
    logic              w_compare;
    logic              w_set_swap;
    logic              w_advance_i;
    logic              w_restart_pass;

    // Address adders; wrap modulo 2^ADDR_W is intentional.
    assign w_addr_a = r_base + ADDR_W'(r_i) * C_STRIDE;
    assign w_addr_b = w_addr_a + C_STRIDE;

    assign w_inversion   = $signed(mem_data_a) > $signed(mem_data_b);
    assign w_last_pair   = (r_i + 32'd2) == r_bound;
    // The exit decision is taken in the PREP cycle itself, so the live
    // length is what counts here.
    assign w_short_array = array_length < 32'd2;
    // bound is at least 2 whenever PASS_END is reached, so no underflow.
    assign w_last_pass   = (r_bound - 32'd1) < 32'd2;

    array_bubble_sort_control u_control (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .inversion    (w_inversion),
        .last_pair    (w_last_pair),
        .short_array  (w_short_array),
        .swapped      (r_swapped),
        .last_pass    (w_last_pass),
        .busy         (busy),
        .done         (done),
        .wr_en        (mem_wr_en),
        .wr_hi        (w_wr_hi),
        .load         (w_load),
        .compare      (w_compare),
        .set_swap     (w_set_swap),
        .advance_i    (w_advance_i),
        .restart_pass (w_restart_pass)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_base       <= '0;
            r_i          <= '0;
            r_bound      <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_swapped    <= 1'b0;
            r_swap_count <= '0;
            r_hold_a     <= array_base;
            r_hold_b     <= array_base + C_STRIDE;
        end else begin
            if (w_load) begin
                r_base       <= array_base;
                r_bound      <= array_length;
                r_i          <= '0;
                r_swapped    <= 1'b0;
                r_swap_count <= '0;
            end else begin
                if (w_restart_pass) begin
                    r_bound   <= r_bound - 32'd1;
                    r_i       <= '0;
                    r_swapped <= 1'b0;
                end else if (w_advance_i) begin
                    r_i <= r_i + 32'd1;
                end
                if (w_set_swap) begin
                    r_swapped    <= 1'b1;
                    r_swap_count <= r_swap_count + 32'd1;
                end
            end
            if (w_compare) begin
                r_hi     <= mem_data_a;
                r_lo     <= mem_data_b;
                r_hold_a <= w_addr_a;
                r_hold_b <= w_addr_b;
            end
        end
    end

    // Read addresses are live only while comparing; elsewhere they hold.
    assign mem_addr_a  = w_compare ? w_addr_a : r_hold_a;
    assign mem_addr_b  = w_compare ? w_addr_b : r_hold_b;
    assign mem_wr_addr = w_wr_hi ? w_addr_b : w_addr_a;
    assign mem_wr_data = w_wr_hi ? r_hi : r_lo;
    assign swap_count  = r_swap_count;

endmodule : array_bubble_sort
`default_nettype wire
